// File: rtl/dmem_byte_ctl_if.sv
// Core-side bus of the byte-addressable data memory: access request in, load result and status out.
interface dmem_byte_ctl_if;
    logic        WE;
    logic [2:0]  funct3;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] ReadData;
    logic        Misaligned;
    logic        Busy;

    modport master (
        output WE, funct3, A, WD,
        input  ReadData, Misaligned, Busy
    );

    modport slave (
        input  WE, funct3, A, WD,
        output ReadData, Misaligned, Busy
    );
endinterface

// File: rtl/dmem_byte_ctl.sv
// RV32I byte-addressable data memory with per-lane stores, load extension and misalignment flag.
// Optional reset-triggered zeroing sweep is compiled in with DMEM_CLEAR_EN.
module dmem_byte_ctl #(
    parameter int unsigned DEPTH = 256
) (
    input  logic           clk,
    input  logic           rst,
    dmem_byte_ctl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx_c;
    logic [1:0]    b_c;
    logic          mis_c;
    logic          busy_c;
    logic          st_en_c;
    logic [3:0]    be_c;
    logic [31:0]   wdat_c;
    logic [31:0]   word_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [31:0]   rd_c;
    logic          clr_en_c;
    logic [AW-1:0] clr_idx_c;
    logic          unused_addr_c;

    assign idx_c         = bus.A[AW+1:2];
    assign b_c           = bus.A[1:0];
    assign unused_addr_c = ^bus.A[31:AW+2];

`ifdef DMEM_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_e;

    state_e        state_q;
    logic [AW-1:0] ptr_q;

    // Sweep FSM: reset (re)starts at word 0, one word per cycle until the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else if (state_q == S_CLEAR) begin
            if (ptr_q == AW'(DEPTH - 1)) begin
                state_q <= S_IDLE;
            end else begin
                ptr_q <= ptr_q + AW'(1);
            end
        end
    end

    assign busy_c    = (state_q == S_CLEAR);
    assign clr_en_c  = rst | busy_c;
    assign clr_idx_c = rst ? '0 : ptr_q;
`else
    logic unused_rst_c;

    assign unused_rst_c = rst;
    assign busy_c       = 1'b0;
    assign clr_en_c     = 1'b0;
    assign clr_idx_c    = '0;
`endif

    // Halfword and word accesses must sit on their natural boundary.
    always_comb begin
        mis_c = 1'b0;
        if (bus.funct3[1:0] == 2'b01 && bus.A[0]) begin
            mis_c = 1'b1;
        end
        if (bus.funct3 == 3'b010 && bus.A[1:0] != 2'b00) begin
            mis_c = 1'b1;
        end
    end

    always_comb begin
        be_c   = 4'b0000;
        wdat_c = bus.WD;
        case (bus.funct3)
            3'b000: begin
                be_c   = 4'(4'b0001 << b_c);
                wdat_c = {4{bus.WD[7:0]}};
            end
            3'b001: begin
                be_c   = bus.A[1] ? 4'b1100 : 4'b0011;
                wdat_c = {2{bus.WD[15:0]}};
            end
            3'b010:  be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
    end

    assign st_en_c = bus.WE & ~busy_c & ~mis_c;

    // Sweep write is issued last so it wins on a shared word.
    always_ff @(posedge clk) begin
        if (st_en_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem_q[idx_c][8*i +: 8] <= wdat_c[8*i +: 8];
                end
            end
        end
        if (clr_en_c) begin
            mem_q[clr_idx_c] <= '0;
        end
    end

    assign word_c = mem_q[idx_c];
    assign byte_c = word_c[8*b_c +: 8];
    assign half_c = bus.A[1] ? word_c[31:16] : word_c[15:0];

    always_comb begin
        rd_c = word_c;
        case (bus.funct3)
            3'b000:  rd_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  rd_c = {24'h000000, byte_c};
            3'b001:  rd_c = {{16{half_c[15]}}, half_c};
            3'b101:  rd_c = {16'h0000, half_c};
            default: rd_c = word_c;
        endcase
    end

    assign bus.ReadData   = busy_c ? 32'h00000000 : rd_c;
    assign bus.Misaligned = mis_c;
    assign bus.Busy       = busy_c;
endmodule

// File: tb/tb_dmem_byte_ctl.sv
// Directed and randomized checks of dmem_byte_ctl against a byte-level reference memory.
module tb_dmem_byte_ctl;
    localparam int unsigned DEPTH = 256;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cnt;
    logic [31:0] ref_mem [DEPTH];

    dmem_byte_ctl_if bus ();

    dmem_byte_ctl #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2) == 1) return 1'b1;
        if (f3 == 3'd2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        int unsigned off;
        logic [7:0]  by;
        logic [15:0] hw;
        w   = ref_mem[(a / 4) % DEPTH];
        off = a % 4;
        by  = 8'((w >> (8 * off)) & 32'hFF);
        hw  = 16'((w >> (16 * (off / 2))) & 32'hFFFF);
        case (f3)
            3'd0:    return 32'($signed(by));
            3'd4:    return 32'(by);
            3'd1:    return 32'($signed(hw));
            3'd5:    return 32'(hw);
            default: return w;
        endcase
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int unsigned wi;
        int unsigned sh;
        logic [31:0] mask;
        wi = (a / 4) % DEPTH;
        if (ref_mis(f3, a)) return;
        case (f3)
            3'd0: begin sh = 8 * (a % 4);        mask = 32'hFF << sh;   end
            3'd1: begin sh = 16 * ((a % 4) / 2); mask = 32'hFFFF << sh; end
            3'd2: begin sh = 0;                  mask = 32'hFFFFFFFF;   end
            default: return;
        endcase
        ref_mem[wi] = (ref_mem[wi] & ~mask) | ((wd << sh) & mask);
    endfunction

    // One access cycle: drive at posedge+1, check combinational outputs, commit at the next edge.
    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input string tag);
        bus.WE = we; bus.funct3 = f3; bus.A = a; bus.WD = wd;
        #1;
        check({tag, "_rd"}, bus.ReadData, ref_load(f3, a));
        check({tag, "_mis"}, 32'(bus.Misaligned), 32'(ref_mis(f3, a)));
        @(posedge clk);
        if (we) ref_store(f3, a, wd);
        #1;
        bus.WE = 1'b0;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                      input logic exp_mis, input string tag);
        bus.WE = 1'b0; bus.funct3 = f3; bus.A = a;
        #1;
        check({tag, "_rd"}, bus.ReadData, exp);
        check({tag, "_mis"}, 32'(bus.Misaligned), 32'(exp_mis));
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 2000 && bus.Busy === 1'b1; i++) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [2:0] f3s [7];
        checks   = 0;
        failures = 0;
        f3s = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        bus.WE = 1'b0; bus.funct3 = 3'd2; bus.A = '0; bus.WD = '0;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge clk);
        #1;

`ifdef DMEM_CLEAR_EN
        check("busy_after_rst", 32'(bus.Busy), 32'd1);
        rst = 1'b0;
        // Store held throughout the sweep must never land.
        bus.WE = 1'b1; bus.funct3 = 3'd2; bus.A = 32'h10; bus.WD = 32'hDEADBEEF;
        #1;
        check("rd_zero_busy", bus.ReadData, 32'h0);
        count_busy(cnt);
        bus.WE = 1'b0;
        check("sweep_len", 32'(cnt), 32'd256);
        for (int i = 0; i < DEPTH; i++) ld(3'd2, 32'(i * 4), 32'h0, 1'b0, "swept");
`else
        check("busy_during_rst", 32'(bus.Busy), 32'd0);
        for (int i = 0; i < DEPTH; i++) op(1'b1, 3'd2, 32'(i * 4), 32'h0, "init");
        op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "st_under_rst");
        check("busy_rst_end", 32'(bus.Busy), 32'd0);
        rst = 1'b0;
        ld(3'd2, 32'h10, 32'hDEADBEEF, 1'b0, "rst_store_kept");
        op(1'b1, 3'd2, 32'h10, 32'h0, "rezero");
`endif

        // Byte/halfword merge
        op(1'b1, 3'd2, 32'h20, 32'h11223344, "sw20");
        op(1'b1, 3'd0, 32'h21, 32'h000000AA, "sb21");
        op(1'b1, 3'd1, 32'h22, 32'h0000BBCC, "sh22");
        ld(3'd2, 32'h20, 32'hBBCCAA44, 1'b0, "merge");

        // Load extension
        op(1'b1, 3'd2, 32'h40, 32'h80FF7F01, "sw40");
        ld(3'd0, 32'h42, 32'hFFFFFFFF, 1'b0, "lb42");
        ld(3'd4, 32'h42, 32'h000000FF, 1'b0, "lbu42");
        ld(3'd1, 32'h42, 32'hFFFF80FF, 1'b0, "lh42");
        ld(3'd5, 32'h42, 32'h000080FF, 1'b0, "lhu42");
        ld(3'd0, 32'h40, 32'h00000001, 1'b0, "lb40");

        // Misalignment
        op(1'b1, 3'd2, 32'h50, 32'h12345678, "sw50");
        op(1'b1, 3'd1, 32'h51, 32'h0000FFFF, "sh51");
        op(1'b1, 3'd2, 32'h52, 32'hFFFFFFFF, "sw52");
        ld(3'd2, 32'h50, 32'h12345678, 1'b0, "lw50");
        ld(3'd1, 32'h53, 32'h00001234, 1'b1, "lh53");
        ld(3'd0, 32'h53, 32'h00000012, 1'b0, "lb53");

        // Address wrap
        op(1'b1, 3'd2, 32'h400, 32'hCAFEF00D, "sw400");
        ld(3'd2, 32'h000, 32'hCAFEF00D, 1'b0, "wrap");

        // Randomized traffic against the reference memory
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if (($urandom % 4) != 0) a = a & 32'h3FF;
            op(1'($urandom % 2), f3s[$urandom % 7], a, $urandom, "rand");
        end
        for (int i = 0; i < DEPTH; i++) op(1'b0, 3'd2, 32'(i * 4), 32'h0, "final");

`ifdef DMEM_CLEAR_EN
        // Reset in the middle of a sweep restarts it
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin @(posedge clk); #1; end
        check("busy_mid_sweep", 32'(bus.Busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(cnt);
        check("restart_len", 32'(cnt), 32'd256);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int i = 0; i < DEPTH; i += 17) op(1'b0, 3'd2, 32'(i * 4), 32'h0, "reswept");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
